// File: rtl/frame_scheduler.sv
// Game/LED-matrix sequencer: one action step pulse per tick, then a row-multiplexed scan of a frame snapshot.
// Optional build macro FRAME_SCHED_BLANK_EN adds one blanked trailing clock to every row slot.
module frame_scheduler #(
    parameter int GS              = 8,
    parameter int ROW_CYCLES      = 4,
    parameter int FRAMES_PER_TICK = 2,
    parameter int SETTLE          = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    input  logic               d_act_i,
    input  logic [GS*GS-1:0]   matrix_i,
    output logic               e_act_o,
    output logic               up_o,
    output logic               down_o,
    output logic [GS-1:0]      row_o,
    output logic [GS-1:0]      col_o,
    output logic               tick_o
);

`ifdef FRAME_SCHED_BLANK_EN
    localparam int SLOT = ROW_CYCLES + 1;
`else
    localparam int SLOT = ROW_CYCLES;
`endif
    localparam int SUB_W = $clog2(SLOT) + 1;
    localparam int ROW_W = $clog2(GS) + 1;
    localparam int FRM_W = $clog2(FRAMES_PER_TICK) + 1;
    localparam int SET_W = $clog2(SETTLE) + 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SLOT - 1);
    localparam logic [SUB_W-1:0] SUB_LIT  = SUB_W'(ROW_CYCLES);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_TICK - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE);

    typedef enum logic [1:0] {ST_ACT, ST_SETTLE, ST_SCAN} state_t;

    state_t             st_q, st_n;
    logic [SET_W-1:0]   set_q, set_n;
    logic [SUB_W-1:0]   sub_q, sub_n;
    logic [ROW_W-1:0]   row_q, row_n;
    logic [FRM_W-1:0]   frm_q, frm_n;
    logic [GS*GS-1:0]   frame_q;
    logic [GS*GS-1:0]   src;
    logic [GS-1:0]      col_n;
    logic               snap, lit_n, tick_n;
    logic               up_lat, down_lat;

    // Next-state: an ACT state with no pulse issued yet (only right after reset) issues it first.
    always_comb begin
        st_n  = st_q;
        set_n = set_q;
        sub_n = sub_q;
        row_n = row_q;
        frm_n = frm_q;
        snap  = 1'b0;
        unique case (st_q)
            ST_ACT: begin
                if (e_act_o) begin
                    st_n  = ST_SETTLE;
                    set_n = SET_W'(1);
                end
            end
            ST_SETTLE: begin
                if (set_q >= SET_LAST && d_act_i) begin
                    st_n  = ST_SCAN;
                    snap  = 1'b1;
                    sub_n = '0;
                    row_n = '0;
                    frm_n = '0;
                end else if (set_q < SET_LAST) begin
                    set_n = set_q + 1'b1;
                end
            end
            ST_SCAN: begin
                if (sub_q == SUB_LAST) begin
                    sub_n = '0;
                    if (row_q == ROW_LAST) begin
                        row_n = '0;
                        if (frm_q == FRM_LAST) begin
                            frm_n = '0;
                            st_n  = ST_ACT;
                        end else begin
                            frm_n = frm_q + 1'b1;
                        end
                    end else begin
                        row_n = row_q + 1'b1;
                    end
                end else begin
                    sub_n = sub_q + 1'b1;
                end
            end
            default: st_n = ST_ACT;
        endcase
    end

    // The first lit row comes straight from matrix_i, since the buffer loads on the same edge.
    always_comb begin
        src   = snap ? matrix_i : frame_q;
        col_n = '0;
        for (int r = 0; r < GS; r++) begin
            if (row_n == ROW_W'(r)) col_n = src[r*GS +: GS];
        end
        lit_n  = (st_n == ST_SCAN) && (sub_n < SUB_LIT);
        tick_n = (st_n == ST_SCAN) && (sub_n == SUB_LAST) &&
                 (row_n == ROW_LAST) && (frm_n == FRM_LAST);
    end

    // Registered state, counters, snapshot buffer and outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_q     <= ST_ACT;
            set_q    <= '0;
            sub_q    <= '0;
            row_q    <= '0;
            frm_q    <= '0;
            frame_q  <= '0;
            up_lat   <= 1'b0;
            down_lat <= 1'b0;
            e_act_o  <= 1'b0;
            up_o     <= 1'b0;
            down_o   <= 1'b0;
            row_o    <= '0;
            col_o    <= '0;
            tick_o   <= 1'b0;
        end else begin
            st_q  <= st_n;
            set_q <= set_n;
            sub_q <= sub_n;
            row_q <= row_n;
            frm_q <= frm_n;
            if (snap) frame_q <= matrix_i;
            // The cycle just ended was ACT when e_act_o is high: reload, otherwise accumulate.
            up_lat   <= e_act_o ? up_i   : (up_lat   | up_i);
            down_lat <= e_act_o ? down_i : (down_lat | down_i);
            e_act_o  <= (st_n == ST_ACT);
            up_o     <= (st_n == ST_ACT) ? (up_lat   | up_i)   : 1'b0;
            down_o   <= (st_n == ST_ACT) ? (down_lat | down_i) : 1'b0;
            row_o    <= lit_n ? (GS'(1) << row_n) : '0;
            col_o    <= lit_n ? col_n : '0;
            tick_o   <= tick_n;
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with default parameters; honours FRAME_SCHED_BLANK_EN.
`timescale 1ns/1ps
module tb_frame_scheduler;

    localparam int GS = 8;
`ifdef FRAME_SCHED_BLANK_EN
    localparam int SLOT = 5;
`else
    localparam int SLOT = 4;
`endif
    localparam int NSCAN  = 2 * GS * SLOT;
    localparam int PERIOD = 1 + 2 + NSCAN;

    logic        clk_i    = 1'b0;
    logic        reset_i  = 1'b1;
    logic        up_i     = 1'b0;
    logic        down_i   = 1'b0;
    logic        d_act_i  = 1'b1;
    logic [63:0] matrix_i = '0;
    logic        e_act_o, up_o, down_o, tick_o;
    logic [7:0]  row_o, col_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    frame_scheduler #(.GS(8), .ROW_CYCLES(4), .FRAMES_PER_TICK(2), .SETTLE(2)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .up_i     (up_i),
        .down_i   (down_i),
        .d_act_i  (d_act_i),
        .matrix_i (matrix_i),
        .e_act_o  (e_act_o),
        .up_o     (up_o),
        .down_o   (down_o),
        .row_o    (row_o),
        .col_o    (col_o),
        .tick_o   (tick_o)
    );

    function automatic logic [7:0] row_of(input logic [63:0] m, input int r);
        logic [63:0] t;
        t = m >> (r * 8);
        return t[7:0];
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Leaves the bench inside cycle 1, the first cycle after release.
    task automatic do_reset();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        up_i = 1'b0; down_i = 1'b0; d_act_i = 1'b1; matrix_i = 64'h0123456789ABCDEF;
        reset_i = 1'b1;
        step();
        step();
        n_cmp++;
        if ({e_act_o, up_o, down_o, tick_o, row_o, col_o} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h expected 0", {e_act_o, up_o, down_o, tick_o, row_o, col_o});
        end
        reset_i = 1'b0;
        step();
        n_cmp++;
        if (e_act_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_first_pulse got %b expected 1", e_act_o);
        end
        n_cmp++;
        if (row_o !== 8'h00) begin
            n_bad++; $display("FAIL reset_act_row got %h expected 00", row_o);
        end
        for (int cyc = 2; cyc <= PERIOD + 1; cyc++) begin
            step();
            n_cmp++;
            if (e_act_o !== 1'(cyc == PERIOD + 1)) begin
                n_bad++; $display("FAIL period_e_act cycle %0d got %b expected %b", cyc, e_act_o, cyc == PERIOD + 1);
            end
            n_cmp++;
            if (tick_o !== 1'(cyc == PERIOD)) begin
                n_bad++; $display("FAIL period_tick cycle %0d got %b expected %b", cyc, tick_o, cyc == PERIOD);
            end
        end
    endtask

    task automatic test_scan(input logic [63:0] mat);
        logic [7:0] er, ec;
        int sub, r;
        matrix_i = mat; d_act_i = 1'b1; up_i = 1'b0; down_i = 1'b0;
        do_reset();
        n_cmp++;
        if (row_o !== 8'h00) begin
            n_bad++; $display("FAIL scan_act_row got %h expected 00", row_o);
        end
        step();
        step();
        n_cmp++;
        if ({row_o, col_o} !== 16'h0) begin
            n_bad++; $display("FAIL scan_settle_blank got %h expected 0000", {row_o, col_o});
        end
        for (int k = 0; k < NSCAN; k++) begin
            step();
            sub = k % SLOT;
            r   = (k / SLOT) % GS;
            er  = (sub < 4) ? (8'h01 << r) : 8'h00;
            ec  = (sub < 4) ? row_of(mat, r) : 8'h00;
            n_cmp++;
            if (row_o !== er) begin
                n_bad++; $display("FAIL scan_row k=%0d got %h expected %h", k, row_o, er);
            end
            n_cmp++;
            if (col_o !== ec) begin
                n_bad++; $display("FAIL scan_col k=%0d got %h expected %h", k, col_o, ec);
            end
            if (k == 0) matrix_i = ~mat;
        end
        step();
        n_cmp++;
        if ({e_act_o, row_o} !== 9'h100) begin
            n_bad++; $display("FAIL scan_next_act got %h expected 100", {e_act_o, row_o});
        end
        step();
        step();
        n_cmp++;
        if (row_o !== 8'h00) begin
            n_bad++; $display("FAIL scan_next_settle got %h expected 00", row_o);
        end
        step();
        n_cmp++;
        if ({row_o, col_o} !== {8'h01, row_of(~mat, 0)}) begin
            n_bad++; $display("FAIL scan_resnap got %h expected %h", {row_o, col_o}, {8'h01, row_of(~mat, 0)});
        end
    endtask

    task automatic test_sticky();
        logic exp_up, exp_dn, is_act;
        matrix_i = '0; d_act_i = 1'b1; up_i = 1'b0; down_i = 1'b0;
        do_reset();
        for (int cyc = 1; cyc <= 4 * PERIOD + 1; cyc++) begin
            if (cyc > 1) step();
            is_act = ((cyc - 1) % PERIOD) == 0;
            exp_up = (cyc == PERIOD + 1) || (cyc == 3 * PERIOD + 1);
            exp_dn = (cyc == 2 * PERIOD + 1) || (cyc == 3 * PERIOD + 1);
            n_cmp++;
            if (e_act_o !== is_act) begin
                n_bad++; $display("FAIL sticky_e_act cycle %0d got %b expected %b", cyc, e_act_o, is_act);
            end
            n_cmp++;
            if ({up_o, down_o} !== {exp_up, exp_dn}) begin
                n_bad++; $display("FAIL sticky_press cycle %0d got %b%b expected %b%b", cyc, up_o, down_o, exp_up, exp_dn);
            end
            up_i   = (cyc == 20) || (cyc == 2 * PERIOD + 10);
            down_i = (cyc == PERIOD + 1) || (cyc == 2 * PERIOD + 10);
        end
        up_i = 1'b0; down_i = 1'b0;
    endtask

    task automatic test_done_stall();
        logic [63:0] mat_b;
        mat_b = 64'h1122334455667788;
        matrix_i = 64'hCAFEF00DDEADBEEF; d_act_i = 1'b0;
        do_reset();
        n_cmp++;
        if (e_act_o !== 1'b1) begin
            n_bad++; $display("FAIL stall_pulse got %b expected 1", e_act_o);
        end
        for (int cyc = 2; cyc <= 12; cyc++) begin
            step();
            n_cmp++;
            if ({e_act_o, row_o} !== 9'h000) begin
                n_bad++; $display("FAIL stall_blank cycle %0d got %h expected 000", cyc, {e_act_o, row_o});
            end
            if (cyc == 5) matrix_i = mat_b;
            if (cyc == 12) d_act_i = 1'b1;
        end
        step();
        n_cmp++;
        if ({row_o, col_o} !== {8'h01, row_of(mat_b, 0)}) begin
            n_bad++; $display("FAIL stall_first_row got %h expected %h", {row_o, col_o}, {8'h01, row_of(mat_b, 0)});
        end
        for (int cyc = 14; cyc <= 12 + NSCAN; cyc++) begin
            step();
            n_cmp++;
            if (tick_o !== 1'(cyc == 12 + NSCAN)) begin
                n_bad++; $display("FAIL stall_tick cycle %0d got %b expected %b", cyc, tick_o, cyc == 12 + NSCAN);
            end
        end
        step();
        n_cmp++;
        if (e_act_o !== 1'b1) begin
            n_bad++; $display("FAIL stall_next_pulse got %b expected 1", e_act_o);
        end
    endtask

    task automatic test_mid_reset();
        int target;
        matrix_i = 64'hA5A5A5A5A5A5A5A5; d_act_i = 1'b1;
        do_reset();
        target = 4 + GS * SLOT + 3 * SLOT + 1;
        for (int cyc = 2; cyc <= target; cyc++) step();
        n_cmp++;
        if ({row_o, col_o} !== 16'h08A5) begin
            n_bad++; $display("FAIL midrst_row3 got %h expected 08a5", {row_o, col_o});
        end
        reset_i = 1'b1;
        step();
        n_cmp++;
        if ({e_act_o, up_o, down_o, tick_o, row_o, col_o} !== 20'h0) begin
            n_bad++; $display("FAIL midrst_outputs got %h expected 0", {e_act_o, up_o, down_o, tick_o, row_o, col_o});
        end
        step();
        reset_i = 1'b0;
        step();
        n_cmp++;
        if ({e_act_o, row_o} !== 9'h100) begin
            n_bad++; $display("FAIL midrst_pulse got %h expected 100", {e_act_o, row_o});
        end
        step();
        step();
        step();
        n_cmp++;
        if ({row_o, col_o} !== 16'h01A5) begin
            n_bad++; $display("FAIL midrst_rescan got %h expected 01a5", {row_o, col_o});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan(64'h8040201008040201);
        test_scan(64'h0123456789ABCDEF);
        test_sticky();
        test_done_stall();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
